// File: rtl/dsp_ctrl_pkg.sv
// ============================================================================
// Module   : dsp_ctrl_pkg
// Purpose  : Shared types and slice control encodings for the MAC sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dsp_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      TAG_NONE  = 3'd0,
      TAG_CLEAR = 3'd1,
      TAG_FIRST = 3'd2,
      TAG_ACC   = 3'd3,
      TAG_HOLD  = 3'd4
   } tag_kind_t;

   typedef struct packed {
      tag_kind_t kind;
      logic      last;
   } tag_t;

   localparam tag_t c_tag_none = '{kind: TAG_NONE, last: 1'b0};

   // OPMODE field order is {Z[2:0], Y[1:0], X[1:0]}
   localparam logic [6:0] OPM_ZERO    = 7'b000_00_00;
   localparam logic [6:0] OPM_M_FIRST = 7'b000_01_01;
   localparam logic [6:0] OPM_M_ACC   = 7'b010_01_01;
   localparam logic [6:0] OPM_HOLD    = 7'b010_00_00;

   localparam logic [3:0] ALUMODE_ADD    = 4'b0000;
   localparam logic [4:0] INMODE_DEFAULT = 5'b00000;
   localparam logic [2:0] CARRYIN_SEL_0  = 3'b000;

   function automatic logic [6:0] tag_opmode(input tag_kind_t kind);
      logic [6:0] opm;
      case (kind)
         TAG_FIRST: opm = OPM_M_FIRST;
         TAG_ACC:   opm = OPM_M_ACC;
         TAG_HOLD:  opm = OPM_HOLD;
         default:   opm = OPM_ZERO;
      endcase
      return opm;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_tag_pipe.sv
// ============================================================================
// Module   : dsp_tag_pipe
// Purpose  : Shift register of operation tags mirroring the slice pipeline,
//            with two selectable read taps.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dsp_tag_pipe
   import dsp_ctrl_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int TAP_A = 0,
   parameter int TAP_B = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  tag_t i_tag,
   output tag_t o_tap_a,
   output tag_t o_tap_b
);

   tag_t r_stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= c_tag_none;
         end
      end else begin
         r_stage[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_tap_a = r_stage[TAP_A];
   assign o_tap_b = r_stage[TAP_B];

endmodule

`default_nettype wire

// File: rtl/dsp_mac_sequencer.sv
// ============================================================================
// Module   : dsp_mac_sequencer
// Purpose  : Streams operand pairs into a DSP slice and sequences OPMODE so P
//            accumulates a dot product; captures P as RESULT at job end.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dsp_mac_sequencer
   import dsp_ctrl_pkg::*;
#(
   parameter int LEN_W   = 10,
   parameter int OPM_TAP = 0,
   parameter int RES_TAP = 2
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             START,
   input  logic [LEN_W-1:0] LEN,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [29:0]      IN_A,
   input  logic [17:0]      IN_B,
   output logic [29:0]      DSP_A,
   output logic [17:0]      DSP_B,
   output logic [6:0]       DSP_OPMODE,
   output logic [3:0]       DSP_ALUMODE,
   output logic [4:0]       DSP_INMODE,
   output logic [2:0]       DSP_CARRYINSEL,
   output logic             DSP_CE,
   input  logic [47:0]      DSP_P,
   output logic             BUSY,
   output logic             DONE,
   output logic [47:0]      RESULT
);

   localparam logic [LEN_W-1:0] c_cnt_one = LEN_W'(1);

   state_t           r_state;
   logic [LEN_W-1:0] r_cnt;
   logic             r_seen_first;
   logic             r_done;
   logic [47:0]      r_result;

   state_t           w_state_next;
   logic [LEN_W-1:0] w_cnt_next;
   logic             w_seen_next;
   logic             w_done_next;
   logic [47:0]      w_result_next;
   logic             w_accept;
   tag_t             w_tag_in;
   tag_t             w_opm_tag;
   tag_t             w_res_tag;

   assign w_accept = IN_VALID && (r_state == ST_RUN);

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt;
      w_seen_next   = r_seen_first;
      w_done_next   = 1'b0;
      w_result_next = r_result;
      w_tag_in      = c_tag_none;
      case (r_state)
         ST_IDLE: begin
            if (START) begin
               if (LEN == '0) begin
                  w_result_next = '0;
                  w_done_next   = 1'b1;
               end else begin
                  w_state_next = ST_RUN;
                  w_cnt_next   = LEN;
                  w_seen_next  = 1'b0;
               end
            end
         end
         ST_RUN: begin
            if (w_accept) begin
               w_tag_in.kind = r_seen_first ? TAG_ACC : TAG_FIRST;
               w_tag_in.last = (r_cnt == c_cnt_one);
               w_seen_next   = 1'b1;
               w_cnt_next    = r_cnt - c_cnt_one;
               if (r_cnt == c_cnt_one) begin
                  w_state_next = ST_DRAIN;
               end
            end else begin
               // Bubble before the first pair keeps P cleared; later ones freeze it
               w_tag_in.kind = r_seen_first ? TAG_HOLD : TAG_CLEAR;
            end
         end
         ST_DRAIN: begin
            w_tag_in.kind = TAG_HOLD;
            if (w_res_tag.last) begin
               w_result_next = DSP_P;
               w_done_next   = 1'b1;
               w_seen_next   = 1'b0;
               w_state_next  = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_seen_first <= 1'b0;
         r_done       <= 1'b0;
         r_result     <= '0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_seen_first <= w_seen_next;
         r_done       <= w_done_next;
         r_result     <= w_result_next;
      end
   end

   dsp_tag_pipe #(
      .DEPTH (RES_TAP + 1),
      .TAP_A (OPM_TAP),
      .TAP_B (RES_TAP)
   ) u_tag_pipe (
      .clk     (CLK),
      .rst_n   (RSTN),
      .i_tag   (w_tag_in),
      .o_tap_a (w_opm_tag),
      .o_tap_b (w_res_tag)
   );

   assign IN_READY       = (r_state == ST_RUN);
   assign BUSY           = (r_state != ST_IDLE);
   assign DSP_CE         = BUSY;
   assign DONE           = r_done;
   assign RESULT         = r_result;
   assign DSP_A          = IN_A;
   assign DSP_B          = IN_B;
   assign DSP_OPMODE     = tag_opmode(w_opm_tag.kind);
   assign DSP_ALUMODE    = ALUMODE_ADD;
   assign DSP_INMODE     = INMODE_DEFAULT;
   assign DSP_CARRYINSEL = CARRYIN_SEL_0;

endmodule

`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
// ============================================================================
// Module   : tb_dsp_mac_sequencer
// Purpose  : Scoreboard bench for dsp_mac_sequencer with a behavioural slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dsp_mac_sequencer;

   logic        CLK;
   logic        RSTN;
   logic        START;
   logic [9:0]  LEN;
   logic        IN_VALID;
   logic        IN_READY;
   logic [29:0] IN_A;
   logic [17:0] IN_B;
   logic [29:0] DSP_A;
   logic [17:0] DSP_B;
   logic [6:0]  DSP_OPMODE;
   logic [3:0]  DSP_ALUMODE;
   logic [4:0]  DSP_INMODE;
   logic [2:0]  DSP_CARRYINSEL;
   logic        DSP_CE;
   logic [47:0] DSP_P;
   logic        BUSY;
   logic        DONE;
   logic [47:0] RESULT;

   dsp_mac_sequencer #(.LEN_W(10), .OPM_TAP(0), .RES_TAP(2)) dut (
      .CLK            (CLK),
      .RSTN           (RSTN),
      .START          (START),
      .LEN            (LEN),
      .IN_VALID       (IN_VALID),
      .IN_READY       (IN_READY),
      .IN_A           (IN_A),
      .IN_B           (IN_B),
      .DSP_A          (DSP_A),
      .DSP_B          (DSP_B),
      .DSP_OPMODE     (DSP_OPMODE),
      .DSP_ALUMODE    (DSP_ALUMODE),
      .DSP_INMODE     (DSP_INMODE),
      .DSP_CARRYINSEL (DSP_CARRYINSEL),
      .DSP_CE         (DSP_CE),
      .DSP_P          (DSP_P),
      .BUSY           (BUSY),
      .DONE           (DONE),
      .RESULT         (RESULT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Slice with AREG=BREG=MREG=PREG=OPMODEREG=1; Z from P when Z=010, X+Y give M when 01/01
   logic signed [29:0] s_a;
   logic signed [17:0] s_b;
   logic signed [47:0] s_m;
   logic signed [47:0] s_p;
   logic        [6:0]  s_opm;

   always @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         s_a   <= '0;
         s_b   <= '0;
         s_m   <= '0;
         s_p   <= '0;
         s_opm <= '0;
      end else if (DSP_CE) begin
         s_a   <= DSP_A;
         s_b   <= DSP_B;
         s_opm <= DSP_OPMODE;
         s_m   <= 48'(s_a) * 48'(s_b);
         s_p   <= ((s_opm[6:4] == 3'b010) ? s_p : 48'sd0) +
                  ((s_opm[3:0] == 4'b0101) ? s_m : 48'sd0);
      end
   end
   assign DSP_P = s_p;

   typedef struct {
      logic [47:0] res;
      bit          zero_len;
   } exp_t;

   exp_t               sb[$];
   logic signed [29:0] job_a[$];
   logic signed [17:0] job_b[$];
   int                 total = 0;
   int                 bad = 0;
   int                 cyc = 0;
   int                 last_acc = 0;
   int                 start_cyc = 0;
   int                 hold_cnt = 0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] ref_dot();
      longint acc = 0;
      foreach (job_a[i]) acc += longint'(job_a[i]) * longint'(job_b[i]);
      return acc[47:0];
   endfunction

   // Monitor: pops the scoreboard whenever DONE is presented
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         cyc++;
         if (RSTN) begin
            if (DSP_OPMODE == 7'b010_00_00) hold_cnt++;
            if (IN_VALID && IN_READY) last_acc = cyc;
            if (START && !BUSY) start_cyc = cyc;
            if (DONE) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_done: got result %h expected no DONE", RESULT);
               end else begin
                  e = sb.pop_front();
                  check("result", RESULT, e.res);
                  check("busy_at_done", 48'(BUSY), 48'd0);
                  check("done_latency", 48'(cyc - (e.zero_len ? start_cyc : last_acc)),
                        e.zero_len ? 48'd1 : 48'd4);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_pair(input logic signed [29:0] a, input logic signed [17:0] b, input int gap);
      int n = 0;
      IN_VALID = 1'b1;
      IN_A     = a;
      IN_B     = b;
      @(negedge CLK);
      while (!IN_READY && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (!IN_READY) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got IN_READY=0 expected 1");
      end
      tick();
      IN_VALID = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic pulse_start(input int len);
      START = 1'b1;
      LEN   = 10'(len);
      tick();
      START = 1'b0;
   endtask

   // gap < 0 selects a random 0..2 bubble count after each pair and before the first
   task automatic run_job(input int gap);
      sb.push_back('{res: ref_dot(), zero_len: (job_a.size() == 0)});
      pulse_start(job_a.size());
      if (gap < 0) repeat ($urandom_range(0, 2)) tick();
      foreach (job_a[i]) send_pair(job_a[i], job_b[i], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || BUSY) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got pending=%0d busy=%0b expected 0 0", sb.size(), BUSY);
      end
   endtask

   task automatic load2(input int a0, input int b0, input int a1, input int b1);
      job_a = {};
      job_b = {};
      job_a.push_back(30'(a0));
      job_b.push_back(18'(b0));
      job_a.push_back(30'(a1));
      job_b.push_back(18'(b1));
   endtask

   initial begin
      #2000000;
      total++;
      bad++;
      $display("FAIL watchdog: got no completion expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int viol;
      int n;
      RSTN = 1'b0;
      START = 1'b0;
      LEN = '0;
      IN_VALID = 1'b0;
      IN_A = '0;
      IN_B = '0;
      repeat (3) tick();
      check("rst_result", RESULT, 48'd0);
      check("rst_done", 48'(DONE), 48'd0);
      check("rst_busy", 48'(BUSY), 48'd0);
      check("rst_ready", 48'(IN_READY), 48'd0);
      check("rst_opmode", 48'(DSP_OPMODE), 48'd0);
      check("rst_ce", 48'(DSP_CE), 48'd0);
      check("alumode", 48'(DSP_ALUMODE), 48'd0);
      check("inmode", 48'(DSP_INMODE), 48'd0);
      check("carryinsel", 48'(DSP_CARRYINSEL), 48'd0);
      RSTN = 1'b1;
      tick();

      // Back-to-back: (2,3),(4,5),(-1,7) -> 19
      load2(2, 3, 4, 5);
      job_a.push_back(-30'sd1);
      job_b.push_back(18'sd7);
      check("ref_19", ref_dot(), 48'd19);
      run_job(0);
      wait_idle();

      // Gapped valid: HOLD opmode must show on the bubble cycles
      load2(1, 1, 2, 2);
      job_a.push_back(30'sd3); job_b.push_back(18'sd3);
      job_a.push_back(30'sd4); job_b.push_back(18'sd4);
      hold_cnt = 0;
      run_job(2);
      wait_idle();
      total++;
      if (hold_cnt < 6) begin
         bad++;
         $display("FAIL hold_cycles: got %0d expected at least 6", hold_cnt);
      end

      // Zero length: DONE next cycle, slice untouched
      job_a = {};
      job_b = {};
      sb.push_back('{res: 48'd0, zero_len: 1'b1});
      viol = 0;
      START = 1'b1;
      LEN = '0;
      tick();
      START = 1'b0;
      repeat (3) begin
         if (DSP_CE || IN_READY) viol++;
         tick();
      end
      check("len0_quiet", 48'(viol), 48'd0);
      wait_idle();

      // Mid-job START ignored, then START on the DONE cycle
      load2(5, 6, 7, 8);
      sb.push_back('{res: ref_dot(), zero_len: 1'b0});
      pulse_start(2);
      send_pair(30'sd5, 18'sd6, 0);
      pulse_start(5);
      send_pair(30'sd7, 18'sd8, 0);
      n = 0;
      while (!DONE && n < 20) begin
         tick();
         n++;
      end
      check("done_seen", 48'(DONE), 48'd1);
      job_a = {30'(-3)};
      job_b = {18'(-4)};
      run_job(0);
      wait_idle();

      // Asynchronous reset mid-job, then a fresh job
      pulse_start(4);
      send_pair(30'sd1, 18'sd2, 0);
      send_pair(30'sd3, 18'sd4, 0);
      #2;
      RSTN = 1'b0;
      #1;
      check("arst_result", RESULT, 48'd0);
      check("arst_busy", 48'(BUSY), 48'd0);
      check("arst_ready", 48'(IN_READY), 48'd0);
      check("arst_opmode", 48'(DSP_OPMODE), 48'd0);
      check("arst_ce", 48'(DSP_CE), 48'd0);
      check("arst_done", 48'(DONE), 48'd0);
      repeat (2) tick();
      RSTN = 1'b1;
      tick();
      job_a = {30'sd6};
      job_b = {18'sd7};
      run_job(0);
      wait_idle();

      // Sign extension at operand extremes
      load2(-(1 << 24), (1 << 17) - 1, -(1 << 24), (1 << 17) - 1);
      check("ref_sign", ref_dot(), 48'(-(64'sd2 * (64'sd1 << 24) * ((64'sd1 << 17) - 1))));
      run_job(0);
      wait_idle();

      // Randomised jobs with random bubbles
      for (int j = 0; j < 15; j++) begin
         int len;
         len = $urandom_range(1, 6);
         job_a = {};
         job_b = {};
         for (int i = 0; i < len; i++) begin
            job_a.push_back(30'($urandom));
            job_b.push_back(18'($urandom));
         end
         run_job(-1);
         if ($urandom_range(0, 1) == 1) wait_idle();
         else begin
            n = 0;
            while (BUSY && n < 50) begin
               tick();
               n++;
            end
         end
      end
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Control sequencer that drives one DSP slice (A/B/M/P registers and OPMODE register enabled) as a streaming multiply-accumulate engine. It accepts a job length, takes operand pairs over a valid/ready stream and forwards them to the slice. It issues per-cycle OPMODE/ALUMODE so the P register accumulates the dot product, then captures the final P as the result. It sits between a requesting engine and the slice top, and owns all of the slice's control and clock-enable pins.

## Interface
- LEN_W, default 10: width of job length.
- OPM_TAP, default 0: tag-pipeline stage that drives DSP_OPMODE. 0 matches AREG=1, MREG=1, OPMODEREG=1.
- RES_TAP, default 2: tag-pipeline stage at which DSP_P holds the result. 2 matches PREG=1.

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- START  in  1  job request, sampled in IDLE only
- LEN  in  LEN_W  number of operand pairs, sampled with START
- IN_VALID  in  1  operand pair valid
- IN_READY  out  1  sequencer accepts pair
- IN_A  in  30  signed operand A
- IN_B  in  18  signed operand B
- DSP_A  out  30  to slice A, combinational copy of IN_A
- DSP_B  out  18  to slice B, combinational copy of IN_B
- DSP_OPMODE  out  7  slice OPMODE
- DSP_ALUMODE  out  4  slice ALUMODE, constant 4'b0000 (Z+X+Y+CIN)
- DSP_INMODE  out  5  constant 5'b00000
- DSP_CARRYINSEL  out  3  constant 3'b000
- DSP_CE  out  1  fanned to every slice CE, equals BUSY
- DSP_P  in  48  slice P
- BUSY  out  1  job in progress
- DONE  out  1  one-cycle pulse, RESULT valid
- RESULT  out  48  signed dot product, held until next DONE

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN on START with LEN≠0. Load remaining counter CNT=LEN.
- IDLE with START and LEN=0: stay IDLE. RESULT←0 and DONE pulses next cycle. No slice activity.
- START is ignored when not IDLE.
- RUN: IN_READY=1. Accept when IN_VALID&IN_READY, then CNT−−. When CNT==1 is accepted → DRAIN.
- DRAIN: IN_READY=0. When the last tag reaches RES_TAP, capture RESULT←DSP_P, pulse DONE, → IDLE.
- Tag pipeline: RES_TAP+1 stages. Each stage holds {kind}, where kind ∈ {NONE, CLEAR, FIRST, ACC, HOLD, LAST-flag}. In RUN/DRAIN, one tag enters stage 0 every cycle:
  - FIRST: accepted pair and no pair accepted yet this job.
  - ACC: accepted pair after the first.
  - CLEAR: no accept, first pair still pending.
  - HOLD: no accept, after the first pair.
  - LAST flag is set on the tag of the final pair.
- Shift every cycle. IDLE inserts NONE.
- DSP_OPMODE, from the tag at OPM_TAP:
  - FIRST → 7'b000_01_01 (X=M, Z=0)
  - ACC → 7'b010_01_01 (X=M, Z=P)
  - HOLD → 7'b010_00_00 (P holds)
  - CLEAR/NONE → 7'b000_00_00
- Arithmetic: 48-bit two's complement wrap, no saturation. Overflow is not flagged.
- Reset (any time, including mid-job): state IDLE, CNT 0, all tags NONE. IN_READY 0, BUSY 0, DONE 0, RESULT 0, DSP_OPMODE 0, DSP_CE 0.

## Timing
- Pair accepted at edge k; the slice latches A/B at k. Tag is at stage 0 after k, so OPMODE is presented before edge k+1 and latched with M at k+1. ALU sums in cycle k+1..k+2. P is valid after k+2 (stage RES_TAP).
- Last pair accepted at edge k: RESULT updates and DONE=1 after edge k+3, one cycle only. BUSY falls at the same edge.
- DSP_CE=1 throughout RUN and DRAIN so bubbles propagate. Bubbles never alter P (HOLD) or leave P cleared (CLEAR).
- A START in the cycle DONE is high is accepted (state already IDLE). Back-to-back jobs therefore have a 1-cycle gap.
- Fixed latency LEN_accept_span+3 cycles from the first accept to DONE.

## Structure
- Shared package dsp_ctrl_pkg:
  - state enum.
  - tag kind enum.
  - OPMODE constants OPM_ZERO, OPM_M_FIRST, OPM_M_ACC, OPM_HOLD.
  - ALUMODE_ADD.
- One sub-module, dsp_tag_pipe: parameterised shift register of tags with a selectable tap. Instantiate once and read two taps (OPM_TAP, RES_TAP).
- Top FSM and counter live in dsp_mac_sequencer. Verification pairs it with the slice top using default register parameters.

## Test plan
- LEN=3, pairs (2,3),(4,5),(−1,7) streamed back-to-back → RESULT=19, DONE exactly 3 cycles after the third accept, BUSY low in the same cycle.
- LEN=4, IN_VALID gapped (1 on, 2 off), pairs (1,1),(2,2),(3,3),(4,4) → RESULT=30. Expected OPMODE sequence includes HOLD (7'b010_00_00) on gap cycles.
- LEN=0 → DONE next cycle, RESULT=0, DSP_CE never asserted, IN_READY stays 0.
- Second START with LEN=5 mid-job → ignored. First job result is unchanged. An immediate START on the DONE cycle with LEN=1, pair (−3,−4) → RESULT=12 and no residue from the previous job.
- RSTN asserted after 2 of 4 accepts → all outputs 0 asynchronously. A new job with LEN=1, pair (6,7) → RESULT=42.
- LEN=2, pairs (−2^24, 2^17−1) twice → RESULT = −2·2^24·(2^17−1) exact in 48 bits (sign-extension check).
